// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and op-decode helpers for the bytewise MEM stage.
package mem_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] MEM_NOP = 4'd0;
  localparam logic [OP_W-1:0] EX_LB   = 4'd1;
  localparam logic [OP_W-1:0] EX_LBU  = 4'd2;
  localparam logic [OP_W-1:0] EX_LH   = 4'd3;
  localparam logic [OP_W-1:0] EX_LHU  = 4'd4;
  localparam logic [OP_W-1:0] EX_LW   = 4'd5;
  localparam logic [OP_W-1:0] EX_LWU  = 4'd6;
  localparam logic [OP_W-1:0] EX_LD   = 4'd7;
  localparam logic [OP_W-1:0] EX_SB   = 4'd8;
  localparam logic [OP_W-1:0] EX_SH   = 4'd9;
  localparam logic [OP_W-1:0] EX_SW   = 4'd10;
  localparam logic [OP_W-1:0] EX_SD   = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_STORE, S_LOAD, S_DONE} mem_state_e;

  // Access size in bytes; 0 marks an op that is illegal for this XLEN.
  function automatic logic [3:0] op_size(input logic [OP_W-1:0] op, input logic rv64);
    case (op)
      EX_LB, EX_LBU, EX_SB: op_size = 4'd1;
      EX_LH, EX_LHU, EX_SH: op_size = 4'd2;
      EX_LW, EX_SW:         op_size = 4'd4;
      EX_LWU:               op_size = rv64 ? 4'd4 : 4'd0;
      EX_LD, EX_SD:         op_size = rv64 ? 4'd8 : 4'd0;
      default:              op_size = 4'd0;
    endcase
  endfunction

  function automatic logic is_signed(input logic [OP_W-1:0] op);
    is_signed = (op == EX_LB) || (op == EX_LH) || (op == EX_LW) || (op == EX_LD);
  endfunction

  function automatic logic is_load(input logic [OP_W-1:0] op);
    is_load = (op >= EX_LB) && (op <= EX_LD);
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] op);
    is_store = (op >= EX_SB) && (op <= EX_SD);
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Sign/zero extension of assembled load bytes from 8*size bits to XLEN.
module mem_load_extend #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [3:0]      size,
  input  logic            sgn,
  output logic [XLEN-1:0] result
);

  logic msb;

  always_comb begin
    case (size)
      4'd1:    msb = data[7];
      4'd2:    msb = data[15];
      4'd4:    msb = data[31];
      default: msb = data[XLEN-1];
    endcase
    result = '0;
    for (int i = 0; i < XLEN; i++)
      result[i] = (i < 8 * int'(size)) ? data[i] : (sgn & msb);
  end

endmodule

// File: rtl/mem_stage_bytewise.sv
// Pipelined MEM stage driving a byte-wide RAM; loads/stores are split into byte transfers.
// Optional macro MEM_ALIGN_CHECK_EN rejects accesses whose address is not a multiple of the size.
module mem_stage_bytewise
  import mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   rd_data_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              rd_enable_i,
  input  logic [OP_W-1:0]   aluop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  output logic [XLEN-1:0]   rd_data_o,
  output logic [4:0]        rd_addr_o,
  output logic              rd_enable_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i,
  output logic              mem_stall_o,
  output logic              misalign_o
);

  localparam int   NUM_LANES = XLEN / 8;
  localparam int   LANE_W    = $clog2(NUM_LANES);
  localparam logic RV64      = (XLEN == 64);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
  } mem_req_t;

  mem_state_e                     state;
  mem_req_t                       req_q;
  logic [3:0]                     cnt;
  logic [NUM_LANES-1:0][7:0]      asm_q;
  logic [NUM_LANES-1:0][7:0]      st_lanes;
  logic [RD_LAT-1:0]              vld_pipe;
  logic [RD_LAT-1:0][2:0]         idx_pipe;

  logic [3:0]        in_size, cur_size, last;
  logic              in_ld, in_st, misal;
  logic              iss, cap;
  logic [2:0]        iss_idx, cap_idx;
  logic [XLEN-1:0]   ext_data, data_c;
  logic [ADDR_W-1:0] a_c;
  logic [7:0]        dout_c;
  logic              wr_c, stall_c, mis_c, en_c;

  assign in_size  = op_size(aluop_i, RV64);
  assign in_ld    = is_load(aluop_i) && (in_size != 4'd0);
  assign in_st    = is_store(aluop_i) && (in_size != 4'd0);
  assign cur_size = op_size(req_q.op, RV64);
  assign last     = cur_size - 4'd1;
  assign st_lanes = rd_data_i;
  assign cap      = vld_pipe[RD_LAT-1];
  assign cap_idx  = idx_pipe[RD_LAT-1];

`ifdef MEM_ALIGN_CHECK_EN
  // Sizes are powers of two up to 8, so the low three address bits decide alignment.
  assign misal = (in_ld || in_st) && ((mem_addr_i[2:0] & (in_size[2:0] - 3'd1)) != 3'd0);
`else
  assign misal = 1'b0;
`endif

  mem_load_extend #(.XLEN(XLEN)) u_ext (
    .data   (asm_q),
    .size   (cur_size),
    .sgn    (is_signed(req_q.op)),
    .result (ext_data)
  );

  // First byte is issued straight from the EX/MEM inputs so no cycle is lost in IDLE.
  always_comb begin
    a_c     = '0;
    dout_c  = '0;
    wr_c    = 1'b0;
    stall_c = 1'b0;
    mis_c   = 1'b0;
    data_c  = '0;
    en_c    = rd_enable_i;
    iss     = 1'b0;
    iss_idx = cnt[2:0];
    case (state)
      S_IDLE: begin
        if (misal) begin
          mis_c = 1'b1;
          en_c  = 1'b0;
        end else if (in_ld) begin
          a_c     = mem_addr_i;
          stall_c = 1'b1;
          iss     = 1'b1;
          iss_idx = 3'd0;
        end else if (in_st) begin
          a_c     = mem_addr_i;
          dout_c  = st_lanes[0];
          wr_c    = 1'b1;
          stall_c = 1'b1;
        end else if (aluop_i == MEM_NOP) begin
          data_c = rd_data_i;
        end
      end
      S_STORE: begin
        a_c     = req_q.addr + ADDR_W'(cnt);
        dout_c  = st_lanes[cnt[LANE_W-1:0]];
        wr_c    = 1'b1;
        stall_c = 1'b1;
      end
      S_LOAD: begin
        stall_c = 1'b1;
        if (cnt < cur_size) begin
          a_c = req_q.addr + ADDR_W'(cnt);
          iss = 1'b1;
        end
      end
      S_DONE: data_c = is_load(req_q.op) ? ext_data : rd_data_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      req_q    <= '0;
      asm_q    <= '0;
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      // Issue-index shift register lines each returning byte up with its lane.
      vld_pipe[0] <= iss;
      idx_pipe[0] <= iss_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
      if (cap) asm_q[cap_idx[LANE_W-1:0]] <= ram_din_i;

      case (state)
        S_IDLE: begin
          if (!misal && (in_ld || in_st)) begin
            req_q.op   <= aluop_i;
            req_q.addr <= mem_addr_i;
            cnt        <= 4'd1;
            if (in_ld)               state <= S_LOAD;
            else if (in_size == 4'd1) state <= S_DONE;
            else                     state <= S_STORE;
          end
        end
        S_STORE: begin
          cnt <= cnt + 4'd1;
          if (cnt == last) state <= S_DONE;
        end
        S_LOAD: begin
          if (iss) cnt <= cnt + 4'd1;
          if (cap && ({1'b0, cap_idx} == last)) state <= S_DONE;
        end
        S_DONE: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Every output is forced low while reset is asserted, including mid-access.
  assign rd_data_o   = rst_n ? data_c : '0;
  assign rd_addr_o   = rst_n ? rd_addr_i : '0;
  assign rd_enable_o = rst_n & en_c;
  assign ram_a_o     = rst_n ? a_c : '0;
  assign ram_dout_o  = rst_n ? dout_c : '0;
  assign ram_wr_o    = rst_n & wr_c;
  assign mem_stall_o = rst_n & stall_c;
  assign misalign_o  = rst_n & mis_c;

endmodule

// File: tb/tb_mem_stage_bytewise.sv
// Scoreboard bench for mem_stage_bytewise with a behavioural byte RAM of configurable read latency.
module tb_mem_stage_bytewise;
  import mem_pkg::*;

  localparam int XLEN = 32, ADDR_W = 32, RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [XLEN-1:0]   rd_data_i, rd_data_o;
  logic [4:0]        rd_addr_i, rd_addr_o;
  logic              rd_enable_i, rd_enable_o;
  logic [OP_W-1:0]   aluop_i;
  logic [ADDR_W-1:0] mem_addr_i, ram_a_o;
  logic [7:0]        ram_dout_o, ram_din_i;
  logic              ram_wr_o, mem_stall_o, misalign_o;

  mem_stage_bytewise #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i),
    .rd_enable_i(rd_enable_i), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
    .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o), .rd_enable_o(rd_enable_o),
    .ram_a_o(ram_a_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o),
    .ram_din_i(ram_din_i), .mem_stall_o(mem_stall_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  // Byte RAM: 4 KiB window, registered read with RD_LAT cycles of latency.
  logic [7:0] mem [0:4095];
  logic [7:0] r1, r2;
  int         n_rd = 0, n_wr = 0;
  always @(posedge clk) begin
    r1 <= mem[ram_a_o[11:0]];
    r2 <= r1;
    if (ram_wr_o) mem[ram_a_o[11:0]] <= ram_dout_o;
    if (rst_n && ram_wr_o) n_wr <= n_wr + 1;
    if (rst_n && !ram_wr_o && ram_a_o != '0) n_rd <= n_rd + 1;
  end
  assign ram_din_i = (RD_LAT == 1) ? r1 : r2;

  typedef struct {
    logic [XLEN-1:0] data;
    int              stalls;
    logic            en;
    logic            mis;
    logic [4:0]      rd;
  } exp_t;

  exp_t     q[$];
  int       n_vec = 0, n_err = 0;
  logic     drv_valid = 1'b0;
  logic [4:0] rd_tag = 5'd1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: counts stall cycles of the presented instruction and checks its result.
  int mon_stalls = 0;
  always @(negedge clk) begin
    if (rst_n && drv_valid) begin
      if (mem_stall_o) mon_stalls++;
      else begin
        if (q.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("rd_data", 64'(rd_data_o), 64'(e.data));
          chk("stall_cycles", 64'(mon_stalls), 64'(e.stalls));
          chk("rd_enable", 64'(rd_enable_o), 64'(e.en));
          chk("misalign", 64'(misalign_o), 64'(e.mis));
          chk("rd_addr", 64'(rd_addr_o), 64'(e.rd));
        end
        mon_stalls = 0;
      end
    end
  end

  task automatic issue(input logic [OP_W-1:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] exp_data, input int exp_stall, input logic exp_mis);
    exp_t e;
    e.data = exp_data; e.stalls = exp_stall; e.en = !exp_mis; e.mis = exp_mis; e.rd = rd_tag;
    q.push_back(e);
    aluop_i = op; mem_addr_i = addr; rd_data_i = data; rd_addr_i = rd_tag; rd_enable_i = 1'b1;
    drv_valid = 1'b1;
    for (int c = 0; ; c++) begin
      @(negedge clk);
      if (!mem_stall_o) break;
      if (c > 40) begin chk("stall_timeout", 1, 0); break; end
    end
    @(posedge clk); #1;
    aluop_i = MEM_NOP; drv_valid = 1'b0;
    rd_tag = rd_tag + 5'd1;
  endtask

  int snap;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'hEE;
    mem[12'h100] = 8'h78; mem[12'h101] = 8'h56; mem[12'h102] = 8'h34; mem[12'h103] = 8'h12;
    mem[12'h104] = 8'hA5; mem[12'h105] = 8'h5A;
    mem[12'h200] = 8'h80;
    mem[12'h210] = 8'h34; mem[12'h211] = 8'h92;
    mem[12'hFFF] = 8'h01; mem[12'h000] = 8'h80;

    rst_n = 1'b0; aluop_i = EX_LW; mem_addr_i = 32'h100; rd_data_i = 32'h1234;
    rd_addr_i = 5'd7; rd_enable_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_enable", 64'(rd_enable_o), 0);
    chk("rst_rd_addr", 64'(rd_addr_o), 0);
    chk("rst_stall", 64'(mem_stall_o), 0);
    chk("rst_ram_a", 64'(ram_a_o), 0);
    chk("rst_rd_data", 64'(rd_data_o), 0);
    aluop_i = MEM_NOP;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    snap = n_rd;
    issue(EX_LW, 32'h100, 32'h0, 32'h12345678, 5, 1'b0);
    chk("lw_reads", 64'(n_rd - snap), 4);
    issue(EX_LB,  32'h200, 32'h0, 32'hFFFFFF80, 2, 1'b0);
    issue(EX_LBU, 32'h200, 32'h0, 32'h00000080, 2, 1'b0);
    issue(EX_LH,  32'h210, 32'h0, 32'hFFFF9234, 3, 1'b0);
    issue(EX_LHU, 32'h210, 32'h0, 32'h00009234, 3, 1'b0);

    snap = n_wr;
    issue(EX_SH, 32'h300, 32'hAABBCCDD, 32'hAABBCCDD, 2, 1'b0);
    chk("sh_writes", 64'(n_wr - snap), 2);
    chk("sh_byte0", 64'(mem[12'h300]), 64'hDD);
    chk("sh_byte1", 64'(mem[12'h301]), 64'hCC);
    chk("sh_no_byte2", 64'(mem[12'h302]), 64'hEE);
    issue(EX_SB, 32'h310, 32'h11223344, 32'h11223344, 1, 1'b0);
    chk("sb_byte0", 64'(mem[12'h310]), 64'h44);
    chk("sb_no_byte1", 64'(mem[12'h311]), 64'hEE);
    issue(EX_SW, 32'h320, 32'hCAFEBABE, 32'hCAFEBABE, 4, 1'b0);
    issue(EX_LW, 32'h320, 32'h0, 32'hCAFEBABE, 5, 1'b0);

    // Back-to-back load then NOP.
    snap = n_rd;
    issue(EX_LW, 32'h100, 32'h0, 32'h12345678, 5, 1'b0);
    issue(MEM_NOP, 32'h0, 32'h5, 32'h5, 0, 1'b0);
    chk("b2b_reads", 64'(n_rd - snap), 4);

    snap = n_rd;
    issue(EX_LD, 32'h100, 32'h77, 32'h0, 0, 1'b0);
    issue(4'hF, 32'h100, 32'h77, 32'h0, 0, 1'b0);
    chk("unknown_reads", 64'(n_rd - snap), 0);

    snap = n_rd;
`ifdef MEM_ALIGN_CHECK_EN
    issue(EX_LW, 32'h102, 32'h0, 32'h0, 0, 1'b1);
    chk("misalign_reads", 64'(n_rd - snap), 0);
`else
    issue(EX_LW, 32'h102, 32'h0, 32'h5AA51234, 5, 1'b0);
    chk("misalign_reads", 64'(n_rd - snap), 4);
`endif

    // Reset in the third cycle of a SW: bytes 0..1 land, the rest never do.
    aluop_i = EX_SW; mem_addr_i = 32'h400; rd_data_i = 32'hCAFEF00D;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wr", 64'(ram_wr_o), 0);
    chk("rst_mid_stall", 64'(mem_stall_o), 0);
    aluop_i = MEM_NOP;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("sw_rst_b0", 64'(mem[12'h400]), 64'h0D);
    chk("sw_rst_b1", 64'(mem[12'h401]), 64'hF0);
    chk("sw_rst_b2", 64'(mem[12'h402]), 64'hEE);
    chk("sw_rst_b3", 64'(mem[12'h403]), 64'hEE);
    issue(MEM_NOP, 32'h0, 32'h5, 32'h5, 0, 1'b0);
    issue(EX_LB, 32'h401, 32'h0, 32'hFFFFFFF0, 2, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
    issue(EX_LHU, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 1'b1);
`else
    // Address wraps from 0xFFFFFFFF to 0x00000000.
    issue(EX_LHU, 32'hFFFFFFFF, 32'h0, 32'h00008001, 3, 1'b0);
`endif

    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
